// File: rtl/dff_write_arbiter_if.sv
// Request/grant bus between requester logic and the shared-register write arbiter.
interface dff_write_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       lock;
    logic [WIDTH-1:0]      q;
    logic [NREQ-1:0]       gnt;
    logic                  ack;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (
        output req, wdata, lock,
        input  q, gnt, ack, owner, busy
    );

    modport slave (
        input  req, wdata, lock,
        output q, gnt, ack, owner, busy
    );
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter/sequencer for a shared WIDTH-bit register.
// Optional owner locking for back-to-back writes is enabled by DFF_ARB_LOCK_EN.
module dff_write_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    dff_write_arbiter_if.slave  bus
);
    localparam int unsigned OW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
`ifdef DFF_ARB_LOCK_EN
    localparam logic [1:0] S_LOCKED = 2'd2;
`endif

    logic [1:0]       state_r, state_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [NREQ-1:0]  gnt_r, gnt_n;
    logic             ack_r, ack_n;
    logic [OW-1:0]    owner_r, owner_n;
    logic             busy_r, busy_n;
    logic [OW-1:0]    ptr_r, ptr_n;

    logic             found_c;
    logic [OW-1:0]    win_c;
    logic [OW-1:0]    sel_c;
    logic [WIDTH-1:0] wsel_c;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        found_c = 1'b0;
        win_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_r) + k) % NREQ;
            if (!found_c && bus.req[OW'(idx)]) begin
                found_c = 1'b1;
                win_c   = OW'(idx);
            end
        end
    end

    // Write-data mux: the IDLE winner, or the current owner while locked.
    always_comb begin
        sel_c  = (state_r == S_IDLE) ? win_c : owner_r;
        wsel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_c == OW'(i)) wsel_c = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        q_n     = q_r;
        gnt_n   = '0;
        ack_n   = 1'b0;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        case (state_r)
            S_IDLE: begin
                if (found_c) begin
                    q_n     = wsel_c;
                    gnt_n   = NREQ'(1) << win_c;
                    ack_n   = 1'b1;
                    owner_n = win_c;
                    ptr_n   = (win_c == OW'(NREQ - 1)) ? '0 : win_c + OW'(1);
                    state_n = S_GRANT;
`ifdef DFF_ARB_LOCK_EN
                    if (bus.lock[win_c]) state_n = S_LOCKED;
`endif
                end
            end
            S_GRANT: state_n = S_IDLE;
`ifdef DFF_ARB_LOCK_EN
            S_LOCKED: begin
                // Dropping lock wins over a same-cycle request: exit with no write.
                if (!bus.lock[owner_r]) begin
                    state_n = S_IDLE;
                end else begin
                    gnt_n = gnt_r;
                    if (bus.req[owner_r]) begin
                        q_n   = wsel_c;
                        ack_n = 1'b1;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

`ifndef DFF_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            q_r     <= '0;
            gnt_r   <= '0;
            ack_r   <= 1'b0;
            owner_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            q_r     <= q_n;
            gnt_r   <= gnt_n;
            ack_r   <= ack_n;
            owner_r <= owner_n;
            busy_r  <= busy_n;
            ptr_r   <= ptr_n;
        end
    end

    assign bus.q     = q_r;
    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed, table-driven bench for dff_write_arbiter (NREQ=4, WIDTH=8).
module tb_dff_write_arbiter;
    logic clk;
    logic rst;

    dff_write_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    dff_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [7:0]  q;
        logic [3:0]  gnt;
        logic        ack;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    int total;
    int bad;
    vec_t tbl[$];
    vec_t seq[$];

    localparam logic [31:0] D = 32'h1312_1110;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [31:0] wd, input logic [7:0] eq,
                                input logic [3:0] eg, input logic ea,
                                input logic [1:0] eo, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.wdata = wd;
        v.q = eq; v.gnt = eg; v.ack = ea; v.owner = eo; v.busy = eb;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst       = v.rst;
        bus.req   = v.req;
        bus.lock  = v.lock;
        bus.wdata = v.wdata;
        @(posedge clk);
        #1;
        cmp("q",     idx, 32'(bus.q),     32'(v.q));
        cmp("gnt",   idx, 32'(bus.gnt),   32'(v.gnt));
        cmp("ack",   idx, 32'(bus.ack),   32'(v.ack));
        cmp("owner", idx, 32'(bus.owner), 32'(v.owner));
        cmp("busy",  idx, 32'(bus.busy),  32'(v.busy));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; bus.req = '0; bus.lock = '0; bus.wdata = '0;

        // Reset with all requesting, then fairness sweep 0,1,2,3,0.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'hF, 4'h0, D, 8'h00, 4'h0, 0, 2'd0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h10, 4'h1, 1, 2'd0, 1));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h11, 4'h2, 1, 2'd1, 1));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h11, 4'h0, 0, 2'd1, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h12, 4'h4, 1, 2'd2, 1));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h12, 4'h0, 0, 2'd2, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h13, 4'h8, 1, 2'd3, 1));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h13, 4'h0, 0, 2'd3, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h10, 4'h1, 1, 2'd0, 1));
        tbl.push_back(mk(0, 4'hF, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        // Idle with no requests, then a single requester.
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 32'h13A5_1110, 8'hA5, 4'h4, 1, 2'd2, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 8'hA5, 4'h0, 0, 2'd2, 0));
        // ptr=3 with requests {0,3}: 3 first, then 0, then 3.
        tbl.push_back(mk(0, 4'h9, 4'h0, D, 8'h13, 4'h8, 1, 2'd3, 1));
        tbl.push_back(mk(0, 4'h9, 4'h0, D, 8'h13, 4'h0, 0, 2'd3, 0));
        tbl.push_back(mk(0, 4'h9, 4'h0, D, 8'h10, 4'h1, 1, 2'd0, 1));
        tbl.push_back(mk(0, 4'h9, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        tbl.push_back(mk(0, 4'h9, 4'h0, D, 8'h13, 4'h8, 1, 2'd3, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 8'h13, 4'h0, 0, 2'd3, 0));
        // Reset during GRANT clears everything including ptr.
        tbl.push_back(mk(0, 4'h2, 4'h0, D, 8'h11, 4'h2, 1, 2'd1, 1));
        tbl.push_back(mk(1, 4'h2, 4'h0, D, 8'h00, 4'h0, 0, 2'd0, 0));
        tbl.push_back(mk(0, 4'h6, 4'h0, D, 8'h11, 4'h2, 1, 2'd1, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, D, 8'h11, 4'h0, 0, 2'd1, 0));

`ifdef DFF_ARB_LOCK_EN
        // ptr=2 here: grant 0 so requester 1 is next in line.
        seq.push_back(mk(0, 4'h1, 4'h0, D, 8'h10, 4'h1, 1, 2'd0, 1));
        seq.push_back(mk(0, 4'h0, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        seq.push_back(mk(0, 4'h3, 4'h2, 32'h1312_0110, 8'h01, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h3, 4'h2, 32'h1312_0210, 8'h02, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h3, 4'h2, 32'h1312_0310, 8'h03, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h3, 4'h2, 32'h1312_0410, 8'h04, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h1, 4'h2, 32'h1312_0910, 8'h04, 4'h2, 0, 2'd1, 1));
        seq.push_back(mk(0, 4'h3, 4'h0, 32'h1312_0510, 8'h04, 4'h0, 0, 2'd1, 0));
        seq.push_back(mk(0, 4'h3, 4'h0, 32'h1312_0510, 8'h10, 4'h1, 1, 2'd0, 1));
        seq.push_back(mk(0, 4'h0, 4'h0, D, 8'h10, 4'h0, 0, 2'd0, 0));
        // Reset while locked.
        seq.push_back(mk(0, 4'h2, 4'h2, 32'h1312_2210, 8'h22, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(1, 4'h2, 4'h2, 32'h1312_2210, 8'h00, 4'h0, 0, 2'd0, 0));
        seq.push_back(mk(0, 4'h0, 4'h0, D, 8'h00, 4'h0, 0, 2'd0, 0));
`else
        // lock is ignored: held req+lock alternates single grants and idle cycles.
        seq.push_back(mk(0, 4'h2, 4'h2, 32'h1312_5A10, 8'h5A, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h2, 4'h2, 32'h1312_5A10, 8'h5A, 4'h0, 0, 2'd1, 0));
        seq.push_back(mk(0, 4'h2, 4'h2, 32'h1312_5B10, 8'h5B, 4'h2, 1, 2'd1, 1));
        seq.push_back(mk(0, 4'h2, 4'h2, 32'h1312_5B10, 8'h5B, 4'h0, 0, 2'd1, 0));
        seq.push_back(mk(1, 4'h2, 4'h2, 32'h1312_5B10, 8'h00, 4'h0, 0, 2'd0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        for (int i = 0; i < seq.size(); i++) apply(seq[i], 100 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit D-flip-flop register. Up to NREQ requesters compete to load the register. The block picks one winner, loads its data into the register, returns a one-hot grant and an ack pulse, and can optionally lock the register to one owner for back-to-back writes. It sits between the requester logic and the dff storage element and is the only path that drives the register's d input.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register width in bits
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level-sensitive
- wdata  input  NREQ*WIDTH  write data; requester i owns slice [i*WIDTH +: WIDTH]
- lock  input  NREQ  per-requester lock request; used only with DFF_ARB_LOCK_EN
- q  output  WIDTH  shared register contents
- gnt  output  NREQ  registered one-hot grant; all zero when idle
- ack  output  1  one-cycle pulse, high in the cycle q shows newly written data
- owner  output  $clog2(NREQ)  index of the last winner
- busy  output  1  high in states GRANT and LOCKED

## Operation
- FSM states:
  - IDLE: no grant is held. If any req bit is set, pick a winner, then go to GRANT, or to LOCKED when locking is enabled and lock[winner] is high.
  - GRANT: gnt and ack are high for one cycle. Always returns to IDLE.
  - LOCKED: the owner holds the register.
    - Each cycle with req[owner]=1: load q and pulse ack; gnt[owner] stays high.
    - Each cycle with lock[owner]=0: leave for IDLE, with no write that cycle.
    - All other requests are ignored.
- Round-robin: keep a pointer ptr.
  - The winner is the first set bit of req found searching ptr, ptr+1, … with wrap modulo NREQ.
  - After each grant from IDLE, ptr becomes winner+1 mod NREQ.
  - Writes inside LOCKED do not move ptr.
- Write: at the same edge that leaves IDLE, q loads wdata of the winner, gnt[winner] is set, ack is set and owner is set to the winner.
- Requests are not queued. A requester that holds req through GRANT is arbitrated again in the next IDLE cycle, with no special priority.
- wdata is sampled only at the write edge. Wdata from requesters that did not win is ignored.

## Timing
- Reset values: q=0, gnt=0, ack=0, owner=0, busy=0, ptr=0, state=IDLE.
- rst has priority over every other event, including a write at the same edge. Reset during GRANT or LOCKED returns the block to IDLE with no pending state.
- Latency: req sampled at edge N gives q, gnt and ack valid after edge N (one cycle).
- Unlocked throughput: at most one write every 2 cycles (IDLE→GRANT→IDLE).
- Locked throughput: one write per cycle while req[owner]=1.
- Simultaneous requests resolve in the same cycle, by ptr order only.
- All-zero req in IDLE: no state change, and gnt, ack and busy stay 0.
- Wrap: with NREQ=4 and ptr=3, requests {0,3} grant 3 first, then 0.
- In LOCKED, if lock[owner]=0 and req[owner]=1 in the same cycle, the block exits with no write.

## Configuration
- DFF_ARB_LOCK_EN
  - Defined: the lock input is honoured and the LOCKED state exists.
  - Undefined: the lock input is ignored, the FSM has only IDLE and GRANT, and every grant is a single write.
  - The port list is identical in both builds.

## Test plan
- Reset: hold rst=1 for 3 cycles with req=4'b1111 → q=0, gnt=0, ack=0, busy=0 throughout. The first grant after release goes to requester 0.
- Single requester: req=4'b0100 with wdata slice 2=8'hA5 for 1 cycle → next cycle q=8'hA5, gnt=4'b0100, ack=1, owner=2. One cycle later ack=0 and gnt=0.
- Fairness: hold req=4'b1111 with slice i = 8'h10+i → grants in order 0,1,2,3,0 on every second cycle, with q following 8'h10, 11, 12, 13, 10.
- Wrap and partial requests: after a grant to 3, req=4'b1001 → grant 0. Then req=4'b1001 again → grant 3.
- Lock (DFF_ARB_LOCK_EN): requester 1 with req=1 and lock=1 for 4 cycles, data 8'h01..04, while req[0]=1 → four consecutive ack pulses and q=8'h04. Requester 0 is granted only after lock[1] drops.
- Reset mid-lock: assert rst during LOCKED → next cycle state is IDLE, q=0 and gnt=0. A build without the macro never holds a grant longer than 1 cycle.
